// File: rtl/sync_fifo_flags_pkg.sv
// Shared FIFO definitions: read-mode encoding and pointer-width helper,
// also used by the UART and AXI blocks that sit either side of this FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// FIFO port bundle: write side, read side, error clear and status flags.
interface sync_fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);

  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          r_en;
  logic                          clr_err;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          full;
  logic                          empty;
  logic                          almost_full;
  logic                          almost_empty;
  logic [ptr_width(DEPTH)-1:0]   count;
  logic                          overflow;
  logic                          underflow;

  // Producer/consumer side of the FIFO
  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  // The FIFO itself
  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flags_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store wdata on an accepted write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: combinational lookup
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with selectable FWFT read mode, fill-level count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
  localparam logic          IS_FWFT = (FWFT == int'(FIFO_FWFT));

  // Elaboration-time parameter legality
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_flags: need AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0]         w_ptr_q, w_ptr_d;
  logic [PW-1:0]         r_ptr_q, r_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [PW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(w_ptr_q[AW-1:0]),
    .wdata(bus.data_in),
    .raddr(r_ptr_q[AW-1:0]),
    .rdata(rd_data)
  );

  // Status flags straight from the pointer registers; acceptance uses pre-edge state
  always_comb begin
    count  = w_ptr_q - r_ptr_q;
    full   = (count == DEPTH_C);
    empty  = (count == '0);
    wr_acc = bus.w_en && !full;
    rd_acc = bus.r_en && !empty;
  end

  // Next-state: pointers, standard-mode output register, sticky errors (set beats clear)
  always_comb begin
    w_ptr_d     = wr_acc ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d     = rd_acc ? r_ptr_q + 1'b1 : r_ptr_q;
    data_out_d  = (rd_acc && !IS_FWFT) ? rd_data : data_out_q;
    overflow_d  = (bus.w_en && full)  || (overflow_q  && !bus.clr_err);
    underflow_d = (bus.r_en && empty) || (underflow_q && !bus.clr_err);
  end

  // State registers with synchronous reset; buffered words are discarded by pointer reset
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output mapping; FWFT presents the head word directly, gated to zero when empty
  always_comb begin
    if (IS_FWFT) begin
      bus.data_out = empty ? '0 : rd_data;
    end else begin
      bus.data_out = data_out_q;
    end
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = (count >= AF_C);
    bus.almost_empty = (count <= AE_C);
    bus.count        = count;
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-mode and FWFT-mode instances, DEPTH=4, AF=3, AE=1.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) std_if ();
  sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) fw_if ();

  sync_fifo_flags #(
    .DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .rst(rst), .bus(std_if.slave)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
  ) u_fw (
    .clk(clk), .rst(rst), .bus(fw_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic std_idle();
    std_if.w_en = 1'b0; std_if.r_en = 1'b0; std_if.clr_err = 1'b0; std_if.data_in = '0;
  endtask

  task automatic std_flags(input string tag, input int unsigned cnt);
    check({tag, "_count"}, 32'(std_if.count), 32'(cnt));
    check({tag, "_full"},  32'(std_if.full),  32'(cnt == 4));
    check({tag, "_empty"}, 32'(std_if.empty), 32'(cnt == 0));
    check({tag, "_af"},    32'(std_if.almost_full),  32'(cnt >= 3));
    check({tag, "_ae"},    32'(std_if.almost_empty), 32'(cnt <= 1));
  endtask

  logic [7:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    std_idle();
    fw_if.w_en = 1'b0; fw_if.r_en = 1'b0; fw_if.clr_err = 1'b0; fw_if.data_in = '0;

    // Reset state
    rst = 1'b1; step(); rst = 1'b0;
    std_flags("rst", 0);
    check("rst_ovf",  32'(std_if.overflow),  0);
    check("rst_unf",  32'(std_if.underflow), 0);
    check("rst_dout", 32'(std_if.data_out),  0);

    // Fill standard mode
    for (int i = 0; i < 4; i++) begin
      std_if.w_en = 1'b1; std_if.data_in = fill_vals[i];
      step();
      std_flags($sformatf("fill%0d", i), i + 1);
    end
    std_idle();

    // Drain standard mode: data one cycle after r_en
    for (int i = 0; i < 4; i++) begin
      std_if.r_en = 1'b1;
      step();
      check($sformatf("drain%0d_dout", i), 32'(std_if.data_out), 32'(fill_vals[i]));
      std_flags($sformatf("drain%0d", i), 3 - i);
    end
    std_idle();

    // Refill, then overflow and clear behaviour
    for (int i = 0; i < 4; i++) begin
      std_if.w_en = 1'b1; std_if.data_in = fill_vals[i];
      step();
    end
    std_if.data_in = 8'h55;
    step();
    std_flags("ovf", 4);
    check("ovf_set", 32'(std_if.overflow), 1);
    std_if.clr_err = 1'b1;
    step();
    check("ovf_set_wins", 32'(std_if.overflow), 1);
    std_if.w_en = 1'b0;
    step();
    check("ovf_clr", 32'(std_if.overflow), 0);
    std_idle();

    // Drain: 0x55 must never appear; extra read underflows and holds data_out
    for (int i = 0; i < 4; i++) begin
      std_if.r_en = 1'b1;
      step();
      check($sformatf("ovdrain%0d_dout", i), 32'(std_if.data_out), 32'(fill_vals[i]));
    end
    step();
    check("unf_set",   32'(std_if.underflow), 1);
    check("unf_dout",  32'(std_if.data_out),  32'h44);
    std_flags("unf", 0);
    std_idle();
    std_if.clr_err = 1'b1;
    step();
    check("unf_clr", 32'(std_if.underflow), 0);
    std_idle();

    // Simultaneous read/write at count 2 across pointer wrap
    std_if.w_en = 1'b1; std_if.data_in = 8'hA0; step();
    std_if.data_in = 8'hA1; step();
    for (int k = 0; k < 8; k++) begin
      std_if.w_en = 1'b1; std_if.r_en = 1'b1; std_if.data_in = 8'(8'hA2 + k);
      step();
      check($sformatf("sim%0d_dout", k), 32'(std_if.data_out), 32'(8'hA0 + k));
      check($sformatf("sim%0d_count", k), 32'(std_if.count), 2);
    end
    std_idle();

    // Fill to full, then write+read at full is a read only
    std_if.w_en = 1'b1; std_if.data_in = 8'hAA; step();
    std_if.data_in = 8'hAB; step();
    std_flags("full2", 4);
    std_if.r_en = 1'b1; std_if.data_in = 8'hCC;
    step();
    std_flags("fullrw", 3);
    check("fullrw_dout", 32'(std_if.data_out), 32'hA8);
    check("fullrw_ovf",  32'(std_if.overflow), 1);
    std_idle();

    // Reset mid-stream at count 3 with overflow set
    rst = 1'b1; step(); rst = 1'b0;
    std_flags("mrst", 0);
    check("mrst_ovf",  32'(std_if.overflow), 0);
    check("mrst_dout", 32'(std_if.data_out), 0);
    std_if.w_en = 1'b1; std_if.data_in = 8'h5A; step();
    std_idle();
    std_if.r_en = 1'b1; step();
    check("mrst_new_dout", 32'(std_if.data_out), 32'h5A);
    std_flags("mrst_new", 0);
    std_idle();

    // FWFT mode
    check("fw_idle_dout",  32'(fw_if.data_out), 0);
    check("fw_idle_empty", 32'(fw_if.empty),    1);
    fw_if.w_en = 1'b1; fw_if.data_in = 8'hA5; step();
    fw_if.w_en = 1'b0;
    check("fw_wr_dout",  32'(fw_if.data_out), 32'hA5);
    check("fw_wr_empty", 32'(fw_if.empty),    0);
    check("fw_wr_count", 32'(fw_if.count),    1);
    fw_if.r_en = 1'b1; step();
    check("fw_pop_dout",  32'(fw_if.data_out), 0);
    check("fw_pop_empty", 32'(fw_if.empty),    1);
    check("fw_pop_unf",   32'(fw_if.underflow), 0);
    step();
    check("fw_unf",       32'(fw_if.underflow), 1);
    check("fw_unf_count", 32'(fw_if.count),     0);
    check("fw_unf_dout",  32'(fw_if.data_out),  0);
    fw_if.r_en = 1'b0;
    fw_if.w_en = 1'b1; fw_if.data_in = 8'hB1; step();
    fw_if.data_in = 8'hB2; step();
    fw_if.w_en = 1'b0;
    check("fw_two_dout",  32'(fw_if.data_out), 32'hB1);
    check("fw_two_count", 32'(fw_if.count),    2);
    fw_if.r_en = 1'b1; step();
    fw_if.r_en = 1'b0;
    check("fw_pop2_dout",  32'(fw_if.data_out), 32'hB2);
    check("fw_pop2_count", 32'(fw_if.count),    1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
